// File: rtl/bitwise_op_arbiter.sv
// Round-robin arbiter sharing one registered NOT/AND/OR/XOR unit among R requesters.
// Define BITWISE_OP_ARBITER_STATS_EN to add a saturating accepted-operation counter (op_count).
module bitwise_op_arbiter #(
  parameter int N = 8,
  parameter int R = 4,
  localparam int IW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [2*R-1:0]  req_op,
  input  logic [N*R-1:0]  req_a,
  input  logic [N*R-1:0]  req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_data,
  output logic [IW-1:0]   rsp_id
`ifdef BITWISE_OP_ARBITER_STATS_EN
  ,
  output logic [31:0]     op_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         st_p1;
  logic [N-1:0]   data_p1;
  logic [IW-1:0]  id_p1;
  logic [IW-1:0]  ptr;

  logic           can_accept;
  logic           any;
  logic           accept;
  logic [IW-1:0]  grant;
  logic [IW:0]    idx;
  logic [1:0]     sel_op;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;

  function automatic logic [N-1:0] bitop(input logic [1:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign can_accept = (st_p1 == EMPTY) || rsp_ready;

  // Search from ptr upward, wrapping modulo R; the first valid index wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < R; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(R))
        idx = idx - (IW+1)'(R);
      if (!any && req_valid[idx[IW-1:0]]) begin
        any   = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end

  assign accept    = can_accept && any;
  assign req_ready = (!rst && accept) ? ({{(R-1){1'b0}}, 1'b1} << grant) : '0;

  assign sel_op = req_op[2*int'(grant) +: 2];
  assign sel_a  = req_a[N*int'(grant) +: N];
  assign sel_b  = req_b[N*int'(grant) +: N];

  // Output stage: request select -> registered result (_p1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_p1   <= EMPTY;
      data_p1 <= '0;
      id_p1   <= '0;
      ptr     <= '0;
    end else if (accept) begin
      st_p1   <= FULL;
      data_p1 <= bitop(sel_op, sel_a, sel_b);
      id_p1   <= grant;
      ptr     <= (grant == IW'(R-1)) ? '0 : grant + IW'(1);
    end else if (rsp_ready) begin
      st_p1   <= EMPTY;
    end
  end

  assign rsp_valid = (st_p1 == FULL);
  assign rsp_data  = data_p1;
  assign rsp_id    = id_p1;

`ifdef BITWISE_OP_ARBITER_STATS_EN
  logic [31:0] cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_p1 <= '0;
    else if (accept)
      cnt_p1 <= sat_inc(cnt_p1);
  end

  assign op_count = cnt_p1;
`endif

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Directed table-driven bench for bitwise_op_arbiter (N=8, R=4), plus reset and stats sequences.
module tb_bitwise_op_arbiter;
  localparam int N = 8;
  localparam int R = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_ready;
  logic [2*R-1:0]  req_op;
  logic [N*R-1:0]  req_a;
  logic [N*R-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [N-1:0]    rsp_data;
  logic [1:0]      rsp_id;
`ifdef BITWISE_OP_ARBITER_STATS_EN
  logic [31:0]     op_count;
`endif

  bitwise_op_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef BITWISE_OP_ARBITER_STATS_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    logic [3:0]  er;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  eid;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // Lane i: op/operand for requester i. Requester 0 NOT, 1 AND, 2 OR, 3 XOR.
  localparam logic [7:0]  OPS = 8'b11_10_01_00;
  localparam logic [31:0] LA  = {4{8'hF0}};
  localparam logic [31:0] LB  = {4{8'h3C}};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic r, input logic [3:0] er,
                     input logic ev, input logic [7:0] ed, input logic [1:0] eid);
    vec_t t;
    t.v = v; t.op = op; t.a = a; t.b = b; t.r = r;
    t.er = er; t.ev = ev; t.ed = ed; t.eid = eid;
    vecs.push_back(t);
  endtask

  // Drive just after a rising edge, check req_ready on the falling edge, results after the next rise.
  task automatic cyc(input string nm, input vec_t t);
    req_valid = t.v; req_op = t.op; req_a = t.a; req_b = t.b; rsp_ready = t.r;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'(t.er));
    @(posedge clk);
    #1;
    chk({nm, "_vld"},  32'(rsp_valid), 32'(t.ev));
    chk({nm, "_data"}, 32'(rsp_data),  32'(t.ed));
    chk({nm, "_id"},   32'(rsp_id),    32'(t.eid));
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] er,
                              input logic ev, input logic [7:0] ed, input logic [1:0] eid);
    vec_t t;
    t.v = v; t.op = OPS; t.a = LA; t.b = LB; t.r = r;
    t.er = er; t.ev = ev; t.ed = ed; t.eid = eid;
    return t;
  endfunction

  // Requester obligation monitor: a pending request must stay valid and stable.
  logic [R-1:0]   pend;
  logic [2*R-1:0] op_q;
  logic [N*R-1:0] a_q, b_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < R; i++)
        if (pend[i] && (!req_valid[i] || req_op[2*i +: 2] != op_q[2*i +: 2] ||
                        req_a[N*i +: N] != a_q[N*i +: N] || req_b[N*i +: N] != b_q[N*i +: N]))
          $error("requester %0d changed a pending request", i);
      pend <= req_valid & ~req_ready;
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '1; req_op = OPS; req_a = LA; req_b = LB; rsp_ready = 1'b0;
    #2;
    chk("rst_vld",   32'(rsp_valid), 32'd0);
    chk("rst_data",  32'(rsp_data),  32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    add(4'b0100, 8'h00, 32'h00A5_0000, 32'h0, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2);
    add(4'b0001, 8'h00, LA, LB, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0);
    add(4'b0001, 8'h01, LA, LB, 1'b1, 4'b0001, 1'b1, 8'h30, 2'd0);
    add(4'b0001, 8'h02, LA, LB, 1'b1, 4'b0001, 1'b1, 8'hFC, 2'd0);
    add(4'b0001, 8'h03, LA, LB, 1'b1, 4'b0001, 1'b1, 8'hCC, 2'd0);
    add(4'b0000, OPS, LA, LB, 1'b1, 4'b0000, 1'b0, 8'hCC, 2'd0);
    add(4'b1000, OPS, LA, LB, 1'b1, 4'b1000, 1'b1, 8'hCC, 2'd3);
    for (int k = 0; k < 2; k++) begin
      add(4'b1111, OPS, LA, LB, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0);
      add(4'b1111, OPS, LA, LB, 1'b1, 4'b0010, 1'b1, 8'h30, 2'd1);
      add(4'b1111, OPS, LA, LB, 1'b1, 4'b0100, 1'b1, 8'hFC, 2'd2);
      add(4'b1111, OPS, LA, LB, 1'b1, 4'b1000, 1'b1, 8'hCC, 2'd3);
    end
    add(4'b0111, OPS, LA, LB, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0);
    add(4'b0110, OPS, LA, LB, 1'b1, 4'b0010, 1'b1, 8'h30, 2'd1);
    add(4'b0100, OPS, LA, LB, 1'b1, 4'b0100, 1'b1, 8'hFC, 2'd2);
    add(4'b0001, OPS, LA, LB, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0);
    for (int k = 0; k < 3; k++)
      add(4'b1010, OPS, LA, LB, 1'b0, 4'b0000, 1'b1, 8'h0F, 2'd0);
    add(4'b1010, OPS, LA, LB, 1'b1, 4'b0010, 1'b1, 8'h30, 2'd1);
    add(4'b1000, OPS, LA, LB, 1'b1, 4'b1000, 1'b1, 8'hCC, 2'd3);
    add(4'b0000, OPS, LA, LB, 1'b1, 4'b0000, 1'b0, 8'hCC, 2'd3);

    foreach (vecs[i])
      cyc($sformatf("v%0d", i), vecs[i]);

    // Async reset while stalled with a pending result and a waiting requester.
    cyc("pre_rst_fill",  mk(4'b0100, 1'b1, 4'b0100, 1'b1, 8'hFC, 2'd2));
    cyc("pre_rst_stall", mk(4'b0010, 1'b0, 4'b0000, 1'b1, 8'hFC, 2'd2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_vld",   32'(rsp_valid), 32'd0);
    chk("async_rst_data",  32'(rsp_data),  32'd0);
    chk("async_rst_id",    32'(rsp_id),    32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst_g1", mk(4'b1010, 1'b1, 4'b0010, 1'b1, 8'h30, 2'd1));
    cyc("post_rst_g3", mk(4'b1000, 1'b1, 4'b1000, 1'b1, 8'hCC, 2'd3));
    cyc("post_rst_idle", mk(4'b0000, 1'b1, 4'b0000, 1'b0, 8'hCC, 2'd3));

`ifdef BITWISE_OP_ARBITER_STATS_EN
    rst = 1'b1;
    #1;
    chk("stat_rst0", op_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++)
      cyc($sformatf("stat_a%0d", k), mk(4'b0001, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0));
    chk("stat_five", op_count, 32'd5);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("stat_rst1", op_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      cyc($sformatf("stat_b%0d", k), mk(4'b0001, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0));
    chk("stat_two", op_count, 32'd2);
    force dut.cnt_p1 = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_p1;
    cyc("stat_s0", mk(4'b0001, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0));
    chk("stat_max", op_count, 32'hFFFF_FFFF);
    cyc("stat_s1", mk(4'b0001, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0));
    chk("stat_sat", op_count, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_op_arbiter.md
Name: bitwise_op_arbiter

Overview:
- Shares one registered bit-wise logic unit among R requesters. The unit performs NOT, AND, OR or XOR on N-bit operands.
- Requesters present operations on per-port valid/ready handshakes.
- A round-robin arbiter grants one request per cycle into a single output stage.
- Results leave on a valid/ready response channel tagged with the requester index. The block sits between requesting datapath units and the combinational bit-wise primitives.

Parameters:
- N, 8, operand and result width in bits (N >= 1)
- R, 4, number of requesters (R >= 2); ID width IW = $clog2(R)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  R  bit i: requester i presents an operation
- req_ready  output  R  bit i: requester i's operation accepted this cycle
- req_op  input  2*R  op for requester i at [2i+1:2i]; 00 NOT a, 01 AND, 10 OR, 11 XOR
- req_a  input  N*R  operand A for requester i at [N*i+N-1:N*i]
- req_b  input  N*R  operand B for requester i, same packing; ignored for NOT
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  N  result
- rsp_id  output  IW  index of requester that issued the result

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer ptr=0.
  - req_ready is combinational and is 0 while rst is high.
- Output stage states:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY or (FULL and rsp_ready), i.e. same-cycle drain-and-refill is allowed.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo R.
  - The first set bit g is the winner.
  - req_ready[g] = can_accept and any(req_valid). All other req_ready bits are 0.
  - At most one req_ready bit is set per cycle.
- Accept (req_valid[g] and req_ready[g] at clock edge):
  - rsp_data <= op(req_a[g], req_b[g]); rsp_id <= g; rsp_valid <= 1.
  - ptr <= (g+1) mod R, wrapping from R-1 to 0.
- Drain with no accept (FULL, rsp_ready=1, no valid request):
  - rsp_valid <= 0.
  - rsp_data and rsp_id hold their last values.
- Stall (FULL, rsp_ready=0):
  - rsp_valid, rsp_data and rsp_id held stable.
  - All req_ready=0 and ptr unchanged.
- ptr changes only on accept. Idle cycles do not move the pointer.
- Latency: one cycle from accept to rsp_valid. Throughput is one op per cycle while rsp_ready=1.
- Requester obligations (checked by bench assertions):
  - Once req_valid[i] is asserted, it and its op/operands stay stable until req_ready[i].
  - Withdrawing a request is illegal.
- Fairness: with all R requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,R-1,0... Any continuously valid requester is granted within R accepts.
- Arithmetic: pure bit-wise; no carries. NOT result = ~a. Result is exactly N bits.
- Reset mid-operation:
  - A pending result is discarded (rsp_valid=0) and ptr returns to 0.
  - A requester that was stalled must re-present its request after reset.
- req_valid changing on a non-granted port while stalled is legal only as a new assertion, never as a withdrawal.

Optional Feature:
- Macro: BITWISE_OP_ARBITER_STATS_EN
- Defined:
  - Adds output port op_count (32 bits): a counter of accepted operations.
  - Reset to 0; increments by 1 on every accept.
  - Saturates at 32'hFFFF_FFFF and does not wrap.
- Undefined:
  - Port and counter are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset then single NOT: N=8; requester 2 sends op=00, a=8'hA5 with rsp_ready=1. Required: req_ready[2]=1 same cycle; next cycle rsp_valid=1, rsp_data=8'h5A, rsp_id=2; ptr=3.
- All ops, requester 0: a=8'hF0, b=8'h3C, issued back to back with rsp_ready=1. Required: results 8'h0F, 8'h30, 8'hFC, 8'hCC on consecutive cycles, all with rsp_id=0.
- Round-robin fairness: R=4, all req_valid=1 for 8 cycles with rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0,1,2,3 and exactly one req_ready bit high per cycle.
- Backpressure: result FULL, rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid. Required:
  - rsp_data and rsp_id stable; req_ready=0; ptr unchanged.
  - When rsp_ready rises, requester 1 is granted in that same cycle (drain+refill), then requester 3.
- Async reset mid-stall: assert rst between clock edges while rsp_valid=1. Required:
  - rsp_valid=0 immediately, without waiting for a clock.
  - After release, the first grant goes to the lowest valid index (from ptr=0).
- Stats (macro defined): perform 5 accepts, then reset, then 2 accepts. Required: op_count reads 5 before reset, 0 during reset, 2 after; a forced-preload saturation check holds at 32'hFFFF_FFFF.
